// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - microprogram sequencer for the 8-bit add/sub/shift accumulator datapath
module alu_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             start,
  input  logic             abort,
  input  logic             prog_we,
  input  logic [2:0]       prog_addr,
  input  logic [8:0]       prog_data,
  output logic             V0,
  output logic             V1,
  output logic             M,
  output logic             s0,
  output logic             LSHL,
  output logic             ld_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [8:0]       mem [DEPTH];
  logic [2:0]       pc, pc_nx;
  logic [2:0]       rcnt, rcnt_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [8:0]       w;

  assign w = mem[pc];

  // Program store; cleared to HALT by reset, writable only while idle
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 9'h100;
    end else if (state == IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      pc      <= 3'd0;
      rcnt    <= 3'd0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      rcnt    <= rcnt_nx;
      cyc_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    rcnt_nx  = rcnt;
    cnt_nx   = cyc_cnt;
    V0       = 1'b0;
    V1       = 1'b0;
    M        = 1'b0;
    s0       = 1'b0;
    LSHL     = 1'b0;
    ld_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = 3'd0;
          rcnt_nx  = 3'd0;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!w[8]) begin
          {V0, V1, M, s0, LSHL} = w[4:0];
          ld_en = 1'b1;
          if (cyc_cnt != '1) cnt_nx = cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (rcnt == w[7:5]) begin
            rcnt_nx = 3'd0;
            // Completing the last word ends the run rather than wrapping pc
            if (pc == 3'd7) state_nx = DONE;
            else            pc_nx    = pc + 3'd1;
          end else begin
            rcnt_nx = rcnt + 3'd1;
          end
        end else begin
          state_nx = DONE;
        end
        if (abort) state_nx = IDLE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microprogram sequencer for the 8-bit add/subtract/shift accumulator datapath. Holds a small writable program of datapath control words and, on `start`, steps through it one word per clock, driving the operand-select, add/subtract and shift/load controls plus a register load enable. An optional per-word repeat count lets one word run for several cycles (e.g. repeated shifts). It reports progress with `busy`, a one-cycle `done` pulse and an executed-cycle count.

## Interface
- `DEPTH`, 8: program words; the address width is fixed at 3 bits, so `DEPTH` must be 8.
- `CNT_W`, 8: width of `cyc_cnt`.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `Clr`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin program at address 0; honoured only in IDLE.
- `abort`  in  1  synchronous abort of a running program.
- `prog_we`  in  1  program-memory write strobe; ignored unless IDLE.
- `prog_addr`  in  3  write address.
- `prog_data`  in  9  word: [8] HALT, [7:5] RPT, [4] V0, [3] V1, [2] M, [1] s0, [0] LSHL.
- `V0`  out  1  selects A (1) or T (0) as the first operand.
- `V1`  out  1  selects B (1) or C (0) as the second operand.
- `M`  out  1  1 = subtract, 0 = add.
- `s0`  out  1  1 = shift left, 0 = parallel load.
- `LSHL`  out  1  serial bit shifted in.
- `ld_en`  out  1  datapath register updates on the next edge only when 1.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `cyc_cnt`  out  CNT_W  datapath cycles executed by the last or current run.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, `pc`=0, `rcnt`=0, `cyc_cnt`=0 and every output 0.
- Reset also fills all program words with 9'h100 (HALT).
- IDLE:
  - `prog_we`=1 writes `prog_data` to `mem[prog_addr]`.
  - `start`=1 moves to RUN with `pc`=0, `rcnt`=0, `cyc_cnt`=0.
  - If `start` and `prog_we` are both high, the write completes and the run starts; word 0 is read after the write.
- RUN, current word w = `mem[pc]`:
  - If w[8]=0, outputs `V0`/`V1`/`M`/`s0`/`LSHL` come combinationally from w, and `ld_en`=1.
  - On the edge, `cyc_cnt` increments, saturating at all-ones.
  - If `rcnt`==w[7:5], then `rcnt`=0 and `pc`=`pc`+1; otherwise `rcnt` increments.
  - A word therefore executes RPT+1 cycles.
  - If w[8]=1 (HALT), `ld_en`=0, all controls are 0, and the next edge moves to DONE.
  - If the word at `pc`=7 completes its last repeat, the next state is DONE; `pc` does not wrap to 0.
- DONE: `done`=1 and `ld_en`=0 for exactly one cycle, then IDLE. `cyc_cnt` holds until the next `start`.
- `abort`=1 in RUN:
  - The next edge goes to IDLE with no `done` pulse; `cyc_cnt` holds.
  - The cycle in which `abort` is sampled still drives its word, so that datapath update happens.
  - `abort` in IDLE or DONE is ignored.
- `start` in RUN or DONE is ignored and not queued. `prog_we` in RUN or DONE is ignored.
- All controls and `ld_en` are 0 in IDLE and DONE.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from just after edge k.
  - The word-0 controls are valid in cycle k..k+1.
  - The datapath captures the word-0 result at edge k+1.
- Latency of a program with N executed non-HALT cycles followed by HALT:
  - HALT is decoded in cycle k+N.
  - `done` is high in cycle k+N+1.
  - The block is back in IDLE after edge k+N+2.
- If the program ends by completing word 7 without HALT, `done` is high in cycle k+N (DEPTH words, no HALT cycle).
- Controls are combinational from registered state and memory, so they change only after `CLK` edges, `Clr`, or IDLE memory writes.
- Asserting `Clr` mid-run:
  - Immediately drops all outputs to 0 and clears the program to HALT.
  - The datapath register is cleared by the same `Clr`.

## Test plan
- Reset: assert `Clr`=0 mid-RUN -> `busy`, `done`, `ld_en`, `cyc_cnt` and all controls are 0 at once; `start` then reaches HALT at `pc`=0 -> `done` 2 cycles after `start`, `cyc_cnt`=0.
- Basic program: A=1, B=4, C=2.
  - Words: 0=0x018 (A+B), 1=0x004 (T-C), 2=0x022 (shift, RPT=1, LSHL=0), 3=0x100.
  - Expected: T=5, then 3, then 6, then 12; `done` in cycle k+5; `cyc_cnt`=4.
- Full program without HALT: all 8 words = 0x010 (A+C) with A=1, C=2 -> T=3 for each cycle, `done` in cycle k+8, `cyc_cnt`=8, `pc` never wraps.
- Repeat: word0=0x0E3 (shift with LSHL=1, RPT=7), word1=0x100, starting from T=0 -> T=8'hFF after 8 cycles, `cyc_cnt`=8.
- Abort: basic program with `abort` high during cycle k+1 -> T=3, IDLE after edge k+2, no `done`, `cyc_cnt`=2.
- Ignored inputs:
  - `start` pulses during RUN and DONE cause no second run.
  - `prog_we` to address 1 during RUN leaves the word unchanged; check by re-running.
